// File: rtl/alusys_ctrl_if.sv
// Control/status bundle between the ALUSystem datapath and its hard-wired controller.
// master = controller side (drives selects), slave = datapath side.
interface alusys_ctrl_if;
   logic [15:0] IROut;
   logic [3:0]  ALUOutFlag;
   logic [1:0]  RF_OutASel;
   logic [1:0]  RF_OutBSel;
   logic [1:0]  RF_FunSel;
   logic [3:0]  RF_RSel;
   logic [3:0]  RF_TSel;
   logic [3:0]  ALU_FunSel;
   logic [1:0]  ARF_OutASel;
   logic [1:0]  ARF_OutBSel;
   logic [1:0]  ARF_FunSel;
   logic [3:0]  ARF_RSel;
   logic        IR_LH;
   logic        IR_Enable;
   logic [1:0]  IR_Funsel;
   logic        Mem_WR;
   logic        Mem_CS;
   logic [1:0]  MuxASel;
   logic [1:0]  MuxBSel;
   logic        MuxCSel;
   logic        Halted;
   logic [2:0]  State;

   modport master (
      input  IROut, ALUOutFlag,
      output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
             ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
             IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
             MuxASel, MuxBSel, MuxCSel, Halted, State
   );

   modport slave (
      output IROut, ALUOutFlag,
      input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
             ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
             IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
             MuxASel, MuxBSel, MuxCSel, Halted, State
   );
endinterface

// File: rtl/alusys_controller.sv
// Hard-wired sequencer for the ALUSystem datapath: two-byte fetch, decode, optional
// second execute cycle for memory ops, and a sticky HALT.
//
// state   | meaning
// CLR     | clear RF, ARF and IR
// FETCH_L | read mem[PC] into IR[7:0], PC++
// FETCH_H | read mem[PC] into IR[15:8], PC++
// DECODE  | execute opcode in IROut[15:12]
// EXEC2   | memory access for LD / ST
// HALT    | idle until reset
module alusys_controller (
   input  logic          Clock,
   input  logic          Reset,
   alusys_ctrl_if.master bus
);

   localparam logic [2:0] S_CLR     = 3'd0;
   localparam logic [2:0] S_FETCH_L = 3'd1;
   localparam logic [2:0] S_FETCH_H = 3'd2;
   localparam logic [2:0] S_DECODE  = 3'd3;
   localparam logic [2:0] S_EXEC2   = 3'd4;
   localparam logic [2:0] S_HALT    = 3'd5;

   logic [2:0] state_q, state_d;
   logic       zflag_q, zflag_d;

   logic [3:0] opcode;
   logic [1:0] rx, ry;
   logic [3:0] rx_oh;
   logic       in_unused;

   logic [1:0] rf_a, rf_b, rf_fun;
   logic [3:0] rf_r, rf_t, alu_fun;
   logic [1:0] arf_a, arf_b, arf_fun;
   logic [3:0] arf_r;
   logic       ir_lh, ir_en;
   logic [1:0] ir_fun;
   logic       mem_wr, mem_cs;
   logic [1:0] mux_a, mux_b;
   logic       mux_c, halted;

   assign opcode    = bus.IROut[15:12];
   assign rx        = bus.IROut[11:10];
   assign ry        = bus.IROut[9:8];
   assign rx_oh     = 4'b1000 >> rx;
   // imm8 and the C/N/O flags feed the datapath only
   assign in_unused = ^{bus.IROut[7:0], bus.ALUOutFlag[2:0]};

   always_comb begin
      state_d = state_q;
      zflag_d = zflag_q;
      rf_a    = 2'b00;
      rf_b    = 2'b00;
      rf_fun  = 2'b00;
      rf_r    = 4'b0000;
      rf_t    = 4'b0000;
      alu_fun = 4'b0000;
      arf_a   = 2'b00;
      arf_b   = 2'b00;
      arf_fun = 2'b00;
      arf_r   = 4'b0000;
      ir_lh   = 1'b0;
      ir_en   = 1'b0;
      ir_fun  = 2'b00;
      mem_wr  = 1'b0;
      mem_cs  = 1'b1;
      mux_a   = 2'b00;
      mux_b   = 2'b00;
      mux_c   = 1'b0;
      halted  = 1'b0;

      case (state_q)
         S_CLR: begin
            rf_r    = 4'b1111;
            rf_t    = 4'b1111;
            arf_r   = 4'b1111;
            ir_en   = 1'b1;
            state_d = S_FETCH_L;
         end
         S_FETCH_L, S_FETCH_H: begin
            mem_cs  = 1'b0;
            ir_en   = 1'b1;
            ir_fun  = 2'b01;
            ir_lh   = (state_q == S_FETCH_H);
            arf_r   = 4'b1000;
            arf_fun = 2'b11;
            state_d = (state_q == S_FETCH_L) ? S_FETCH_H : S_DECODE;
         end
         S_DECODE: begin
            state_d = S_FETCH_L;
            case (opcode)
               4'h0: begin
                  mux_a  = 2'b10;
                  rf_fun = 2'b01;
                  rf_r   = rx_oh;
               end
               4'h1, 4'h2: begin
                  mux_b   = 2'b10;
                  arf_fun = 2'b01;
                  arf_r   = 4'b0100;
                  state_d = S_EXEC2;
               end
               4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                  rf_a    = rx;
                  rf_b    = ry;
                  mux_a   = 2'b00;
                  rf_fun  = 2'b01;
                  rf_r    = rx_oh;
                  zflag_d = bus.ALUOutFlag[3];
                  case (opcode)
                     4'h3:    alu_fun = 4'b0100;
                     4'h4:    alu_fun = 4'b0110;
                     4'h5:    alu_fun = 4'b0111;
                     4'h6:    alu_fun = 4'b1000;
                     4'h7:    alu_fun = 4'b1001;
                     default: alu_fun = 4'b0010;
                  endcase
               end
               4'h9: begin
                  rf_fun = 2'b11;
                  rf_r   = rx_oh;
               end
               4'hA: begin
                  rf_fun = 2'b10;
                  rf_r   = rx_oh;
               end
               4'hB, 4'hC, 4'hD: begin
                  // BRA always; BEQ/BNE on the zero flag latched by the last ALU op
                  if (opcode == 4'hB || (opcode == 4'hC && zflag_q) ||
                      (opcode == 4'hD && !zflag_q)) begin
                     mux_b   = 2'b10;
                     arf_fun = 2'b01;
                     arf_r   = 4'b1000;
                  end
               end
               4'hF:    state_d = S_HALT;
               default: ;
            endcase
         end
         S_EXEC2: begin
            state_d = S_FETCH_L;
            if (opcode == 4'h1) begin
               arf_b  = 2'b01;
               mem_cs = 1'b0;
               mux_a  = 2'b01;
               rf_fun = 2'b01;
               rf_r   = rx_oh;
            end else if (opcode == 4'h2) begin
               arf_b  = 2'b01;
               rf_a   = rx;
               mem_cs = 1'b0;
               mem_wr = 1'b1;
            end
         end
         S_HALT:  halted = 1'b1;
         default: state_d = S_CLR;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= S_CLR;
         zflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         zflag_q <= zflag_d;
      end
   end

   // Reset overrides decode combinationally so an aborted store never strobes memory
   assign bus.RF_OutASel  = Reset ? rf_a    : 2'b00;
   assign bus.RF_OutBSel  = Reset ? rf_b    : 2'b00;
   assign bus.RF_FunSel   = Reset ? rf_fun  : 2'b00;
   assign bus.RF_RSel     = Reset ? rf_r    : 4'b0000;
   assign bus.RF_TSel     = Reset ? rf_t    : 4'b0000;
   assign bus.ALU_FunSel  = Reset ? alu_fun : 4'b0000;
   assign bus.ARF_OutASel = Reset ? arf_a   : 2'b00;
   assign bus.ARF_OutBSel = Reset ? arf_b   : 2'b00;
   assign bus.ARF_FunSel  = Reset ? arf_fun : 2'b00;
   assign bus.ARF_RSel    = Reset ? arf_r   : 4'b0000;
   assign bus.IR_LH       = Reset ? ir_lh   : 1'b0;
   assign bus.IR_Enable   = Reset ? ir_en   : 1'b0;
   assign bus.IR_Funsel   = Reset ? ir_fun  : 2'b00;
   assign bus.Mem_WR      = Reset ? mem_wr  : 1'b0;
   assign bus.Mem_CS      = Reset ? mem_cs  : 1'b1;
   assign bus.MuxASel     = Reset ? mux_a   : 2'b00;
   assign bus.MuxBSel     = Reset ? mux_b   : 2'b00;
   assign bus.MuxCSel     = Reset ? mux_c   : 1'b0;
   assign bus.Halted      = Reset ? halted  : 1'b0;
   assign bus.State       = state_q;

endmodule

// File: tb/tb_alusys_controller.sv
// Directed vector bench for alusys_controller: decode table plus hand-written
// reset, halt and store-abort sequences.
module tb_alusys_controller;

   localparam logic [2:0] S_CLR     = 3'd0;
   localparam logic [2:0] S_FETCH_L = 3'd1;
   localparam logic [2:0] S_FETCH_H = 3'd2;
   localparam logic [2:0] S_DECODE  = 3'd3;
   localparam logic [2:0] S_EXEC2   = 3'd4;
   localparam logic [2:0] S_HALT    = 3'd5;

   typedef struct packed {
      logic [1:0] rf_a;
      logic [1:0] rf_b;
      logic [1:0] rf_fun;
      logic [3:0] rf_r;
      logic [3:0] rf_t;
      logic [3:0] alu;
      logic [1:0] arf_a;
      logic [1:0] arf_b;
      logic [1:0] arf_fun;
      logic [3:0] arf_r;
      logic       ir_lh;
      logic       ir_en;
      logic [1:0] ir_fun;
      logic       mem_wr;
      logic       mem_cs;
      logic [1:0] mux_a;
      logic [1:0] mux_b;
      logic       mux_c;
      logic       halted;
   } ctrl_t;

   typedef struct {
      logic [15:0] ir;
      logic [3:0]  flag;
      ctrl_t       dec;
      logic [2:0]  nxt;
      ctrl_t       ex;
   } vec_t;

   logic Clock;
   logic Reset;
   int   n_cmp;
   int   n_err;

   alusys_ctrl_if bus ();

   alusys_controller dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.master)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic ctrl_t idle_v();
      ctrl_t c;
      c = '0;
      c.mem_cs = 1'b1;
      return c;
   endfunction

   function automatic ctrl_t rf_v(logic [1:0] mux_a, logic [1:0] fun, logic [3:0] r);
      ctrl_t c;
      c = idle_v();
      c.mux_a  = mux_a;
      c.rf_fun = fun;
      c.rf_r   = r;
      return c;
   endfunction

   function automatic ctrl_t alu_v(logic [1:0] a, logic [1:0] b, logic [3:0] op, logic [3:0] r);
      ctrl_t c;
      c = rf_v(2'b00, 2'b01, r);
      c.rf_a = a;
      c.rf_b = b;
      c.alu  = op;
      return c;
   endfunction

   function automatic ctrl_t arf_load_v(logic [3:0] r);
      ctrl_t c;
      c = idle_v();
      c.mux_b   = 2'b10;
      c.arf_fun = 2'b01;
      c.arf_r   = r;
      return c;
   endfunction

   function automatic ctrl_t sample();
      ctrl_t c;
      c.rf_a    = bus.RF_OutASel;
      c.rf_b    = bus.RF_OutBSel;
      c.rf_fun  = bus.RF_FunSel;
      c.rf_r    = bus.RF_RSel;
      c.rf_t    = bus.RF_TSel;
      c.alu     = bus.ALU_FunSel;
      c.arf_a   = bus.ARF_OutASel;
      c.arf_b   = bus.ARF_OutBSel;
      c.arf_fun = bus.ARF_FunSel;
      c.arf_r   = bus.ARF_RSel;
      c.ir_lh   = bus.IR_LH;
      c.ir_en   = bus.IR_Enable;
      c.ir_fun  = bus.IR_Funsel;
      c.mem_wr  = bus.Mem_WR;
      c.mem_cs  = bus.Mem_CS;
      c.mux_a   = bus.MuxASel;
      c.mux_b   = bus.MuxBSel;
      c.mux_c   = bus.MuxCSel;
      c.halted  = bus.Halted;
      return c;
   endfunction

   task automatic tick();
      @(negedge Clock);
   endtask

   task automatic chk_ctrl(input string name, input ctrl_t exp);
      ctrl_t act;
      #1;
      act = sample();
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string name, input logic [2:0] exp);
      #1;
      n_cmp++;
      if (bus.State !== exp) begin
         n_err++;
         $display("FAIL %s: state got %0d expected %0d", name, bus.State, exp);
      end
   endtask

   vec_t  vecs[19];
   ctrl_t clr_v, fl_v, fh_v, halt_v, st_ex, ld_ex;

   initial begin
      n_cmp = 0;
      n_err = 0;

      clr_v         = idle_v();
      clr_v.rf_r    = 4'b1111;
      clr_v.rf_t    = 4'b1111;
      clr_v.arf_r   = 4'b1111;
      clr_v.ir_en   = 1'b1;
      fl_v          = idle_v();
      fl_v.mem_cs   = 1'b0;
      fl_v.ir_en    = 1'b1;
      fl_v.ir_fun   = 2'b01;
      fl_v.arf_r    = 4'b1000;
      fl_v.arf_fun  = 2'b11;
      fh_v          = fl_v;
      fh_v.ir_lh    = 1'b1;
      halt_v        = idle_v();
      halt_v.halted = 1'b1;
      st_ex         = idle_v();
      st_ex.arf_b   = 2'b01;
      st_ex.rf_a    = 2'b11;
      st_ex.mem_cs  = 1'b0;
      st_ex.mem_wr  = 1'b1;
      ld_ex         = rf_v(2'b01, 2'b01, 4'b0100);
      ld_ex.arf_b   = 2'b01;
      ld_ex.mem_cs  = 1'b0;

      // zflag history: 0 -> SUB(Z=1) -> ADD(Z=0) -> INC keeps 0 -> XOR/AND 1 -> OR 0 -> NOT 1
      vecs[0]  = '{16'h0C2A, 4'b0000, rf_v(2'b10, 2'b01, 4'b0001),             S_FETCH_L, idle_v()};
      vecs[1]  = '{16'h2D50, 4'b0000, arf_load_v(4'b0100),                      S_EXEC2,   st_ex};
      vecs[2]  = '{16'h1410, 4'b0000, arf_load_v(4'b0100),                      S_EXEC2,   ld_ex};
      vecs[3]  = '{16'h4100, 4'b1000, alu_v(2'b00, 2'b01, 4'b0110, 4'b1000),    S_FETCH_L, idle_v()};
      vecs[4]  = '{16'hC020, 4'b0000, arf_load_v(4'b1000),                      S_FETCH_L, idle_v()};
      vecs[5]  = '{16'hD033, 4'b0000, idle_v(),                                 S_FETCH_L, idle_v()};
      vecs[6]  = '{16'h3AF0, 4'b0000, alu_v(2'b10, 2'b10, 4'b0100, 4'b0010),    S_FETCH_L, idle_v()};
      vecs[7]  = '{16'hC020, 4'b1000, idle_v(),                                 S_FETCH_L, idle_v()};
      vecs[8]  = '{16'hD044, 4'b0000, arf_load_v(4'b1000),                      S_FETCH_L, idle_v()};
      vecs[9]  = '{16'h9000, 4'b1000, rf_v(2'b00, 2'b11, 4'b1000),              S_FETCH_L, idle_v()};
      vecs[10] = '{16'hC055, 4'b0000, idle_v(),                                 S_FETCH_L, idle_v()};
      vecs[11] = '{16'hAC00, 4'b0000, rf_v(2'b00, 2'b10, 4'b0001),              S_FETCH_L, idle_v()};
      vecs[12] = '{16'h7400, 4'b1000, alu_v(2'b01, 2'b00, 4'b1001, 4'b0100),    S_FETCH_L, idle_v()};
      vecs[13] = '{16'h5300, 4'b1000, alu_v(2'b00, 2'b11, 4'b0111, 4'b1000),    S_FETCH_L, idle_v()};
      vecs[14] = '{16'h6D00, 4'b0000, alu_v(2'b11, 2'b01, 4'b1000, 4'b0001),    S_FETCH_L, idle_v()};
      vecs[15] = '{16'h8800, 4'b1000, alu_v(2'b10, 2'b00, 4'b0010, 4'b0010),    S_FETCH_L, idle_v()};
      vecs[16] = '{16'hB0FF, 4'b0000, arf_load_v(4'b1000),                      S_FETCH_L, idle_v()};
      vecs[17] = '{16'hC001, 4'b0000, arf_load_v(4'b1000),                      S_FETCH_L, idle_v()};
      vecs[18] = '{16'hE000, 4'b1000, idle_v(),                                 S_FETCH_L, idle_v()};

      Reset          = 1'b0;
      bus.IROut      = 16'hE000;
      bus.ALUOutFlag = 4'b0000;

      tick();
      chk_state("rst1 state", S_CLR);
      chk_ctrl("rst1 idle", idle_v());
      tick();
      chk_state("rst2 state", S_CLR);
      chk_ctrl("rst2 idle", idle_v());
      Reset = 1'b1;
      chk_ctrl("clr vec", clr_v);
      tick();
      chk_state("fetch_l state", S_FETCH_L);
      chk_ctrl("fetch_l vec", fl_v);
      tick();
      chk_state("fetch_h state", S_FETCH_H);
      chk_ctrl("fetch_h vec", fh_v);
      tick();
      chk_state("decode state", S_DECODE);
      chk_ctrl("nop decode", idle_v());
      tick();

      for (int i = 0; i < 19; i++) begin
         bus.IROut      = vecs[i].ir;
         bus.ALUOutFlag = vecs[i].flag;
         chk_state($sformatf("vec%0d fetch_l", i), S_FETCH_L);
         tick();
         tick();
         chk_state($sformatf("vec%0d decode state", i), S_DECODE);
         chk_ctrl($sformatf("vec%0d decode", i), vecs[i].dec);
         tick();
         chk_state($sformatf("vec%0d next", i), vecs[i].nxt);
         if (vecs[i].nxt == S_EXEC2) begin
            chk_ctrl($sformatf("vec%0d exec2", i), vecs[i].ex);
            tick();
            chk_state($sformatf("vec%0d after exec2", i), S_FETCH_L);
         end
      end

      // HLT holds until reset
      bus.IROut = 16'hF000;
      tick();
      tick();
      chk_ctrl("hlt decode", idle_v());
      tick();
      for (int k = 0; k < 20; k++) begin
         chk_state($sformatf("halt%0d state", k), S_HALT);
         chk_ctrl($sformatf("halt%0d vec", k), halt_v);
         tick();
      end
      Reset = 1'b0;
      chk_ctrl("halt rst idle", idle_v());
      tick();
      chk_state("halt rst state", S_CLR);
      Reset = 1'b1;
      tick();
      chk_state("post halt fetch", S_FETCH_L);

      // reset during the store cycle must suppress the write
      bus.IROut = 16'h2D50;
      tick();
      tick();
      tick();
      chk_state("abort exec2 state", S_EXEC2);
      chk_ctrl("abort pre vec", st_ex);
      Reset = 1'b0;
      chk_ctrl("abort idle", idle_v());
      tick();
      chk_state("abort state", S_CLR);
      Reset = 1'b1;
      tick();
      chk_state("abort fetch", S_FETCH_L);

      // zflag was 1 before the resets; BEQ must now fall through
      bus.IROut = 16'hC020;
      tick();
      tick();
      chk_ctrl("beq after rst", idle_v());
      tick();
      chk_state("beq after rst next", S_FETCH_L);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alusys_controller.md
Name: alusys_controller

Overview:
Hard-wired control unit that sequences the ALUSystem datapath: register file (RF), address register file (ARF), ALU, instruction register (IR), memory and the A/B/C muxes. It fetches a 16-bit instruction as two bytes and decodes it. It then drives every datapath select line, cycle by cycle, for a 16-opcode instruction set. It sits directly above ALUSystem and is its only driver in the top level.

Parameters:
None.

Ports:
Clock  in  1  system clock; all state changes on rising edge
Reset  in  1  synchronous, active-low reset
IROut  in  16  IR contents; [15:12] opcode, [11:10] Rx, [9:8] Ry, [7:0] imm8/address
ALUOutFlag  in  4  ALU flags {Z,C,N,O}, bit3 = Z
RF_OutASel, RF_OutBSel  out  2 each  RF read selects (00..11 = R1..R4)
RF_FunSel  out  2  00 clear, 01 load, 10 decrement, 11 increment (same encoding for ARF_FunSel and IR_Funsel)
RF_RSel, RF_TSel  out  4 each  one-hot write enables; bit3 = R1/T1 .. bit0 = R4/T4
ALU_FunSel  out  4  0000 pass A, 0010 NOT A, 0100 A+B, 0110 A-B, 0111 AND, 1000 OR, 1001 XOR
ARF_OutASel, ARF_OutBSel  out  2 each  00 PC, 01 AR, 10 SP, 11 PCpast; OutB drives Address
ARF_FunSel  out  2  see RF_FunSel
ARF_RSel  out  4  one-hot enables; bit3 PC, bit2 AR, bit1 SP, bit0 PCpast
IR_LH  out  1  0 loads IR[7:0], 1 loads IR[15:8]
IR_Enable  out  1  IR write enable
IR_Funsel  out  2  see RF_FunSel
Mem_WR  out  1  1 write, 0 read
Mem_CS  out  1  active-low chip select
MuxASel  out  2  RF load source: 00 ALUOut, 01 MemoryOut, 10 IROut[7:0], 11 ARF_AOut
MuxBSel  out  2  ARF load source: same encoding as MuxASel
MuxCSel  out  1  ALU A input: 0 RF AOut, 1 ARF_AOut
Halted  out  1  1 while in HALT
State  out  3  current state code, for debug

Behaviour:
- States and codes: CLR=0, FETCH_L=1, FETCH_H=2, DECODE=3, EXEC2=4, HALT=5.
- Outputs are combinational from the registered state and IROut. The idle vector is:
  - RF_RSel = RF_TSel = ARF_RSel = 0000, IR_Enable = 0
  - Mem_CS = 1, Mem_WR = 0
  - all selects and ALU_FunSel = 0
- Every output not named below takes its idle value.
- Reset: while Reset = 0 at a rising edge, state <= CLR, zflag <= 0, and the outputs take the idle vector.
- CLR (one cycle): RF/ARF FunSel = 00 with RSel = TSel = ARF_RSel = 1111; IR_Enable = 1, IR_Funsel = 00. All registers are zero on exit. Next state FETCH_L.
- FETCH_L:
  - Memory read: ARF_OutBSel = 00, Mem_CS = 0, Mem_WR = 0.
  - IR_Enable = 1, IR_Funsel = 01, IR_LH = 0.
  - PC increment: ARF_RSel = 1000, ARF_FunSel = 11.
  - Next state FETCH_H.
- FETCH_H: same as FETCH_L but IR_LH = 1. Next state DECODE; IROut is valid in DECODE.
- DECODE executes the opcode in IROut[15:12]. Rx enable = one-hot of IROut[11:10].
  - 0 LDI: MuxASel = 10, RF_FunSel = 01, RF_RSel = Rx. Next FETCH_L.
  - 1 LD: AR <- imm8 (MuxBSel = 10, ARF_FunSel = 01, ARF_RSel = 0100). Next EXEC2.
  - 2 ST: AR <- imm8 as for LD. Next EXEC2.
  - 3..7 ADD/SUB/AND/OR/XOR: OutASel = Rx, OutBSel = Ry, MuxCSel = 0, ALU code per opcode, MuxASel = 00, RF load Rx, zflag <= ALUOutFlag[3]. Next FETCH_L.
  - 8 NOT: as 3..7 with ALU code 0010. Next FETCH_L.
  - 9 INC Rx / A DEC Rx: RF_FunSel = 11 / 10, RSel = Rx. zflag unchanged. Next FETCH_L.
  - B BRA: PC <- imm8 (MuxBSel = 10, ARF_FunSel = 01, ARF_RSel = 1000). Next FETCH_L.
  - C BEQ / D BNE: do BRA if zflag = 1 / 0, otherwise idle. Next FETCH_L.
  - E NOP: idle. Next FETCH_L.
  - F HLT: idle. Next HALT.
- EXEC2, LD: ARF_OutBSel = 01, Mem_CS = 0, MuxASel = 01, RF load Rx.
- EXEC2, ST: ARF_OutBSel = 01, RF_OutASel = Rx, MuxCSel = 0, ALU 0000, Mem_CS = 0, Mem_WR = 1.
- EXEC2 next state is FETCH_L.
- HALT: idle vector, Halted = 1. Only Reset leaves HALT.
- Latency in cycles, fetch included: LDI/ALU/INC/DEC/branch/NOP = 3, LD/ST = 4.
- PC wraps 8'hFF -> 8'h00 inside the ARF; the controller does not detect wrap.
- Rx = Ry is legal: the ALU reads both operands before the write edge.
- Reset asserted in any state, including EXEC2 mid-store, aborts the instruction. In that cycle Mem_CS = 1, so no memory write occurs.

Test Plan:
- Reset low for 2 cycles, then high -> state sequence CLR, FETCH_L, FETCH_H, DECODE; ARF_RSel = 1111 and ARF_FunSel = 00 in CLR; Mem_CS = 1 throughout reset.
- IROut = 16'h0C2A (LDI R4,42) in DECODE -> MuxASel = 10, RF_RSel = 0001, RF_FunSel = 01; next state FETCH_L; 3 cycles per instruction.
- IROut = 16'h2D50 (ST R4,[50h]) -> DECODE: ARF_RSel = 0100, MuxBSel = 10; EXEC2: Mem_WR = 1, Mem_CS = 0, ARF_OutBSel = 01, RF_OutASel = 11.
- ALUOutFlag = 4'b1000 during SUB (16'h4100), then IROut = 16'hC020 -> PC load with ARF_RSel = 1000, MuxBSel = 10. Repeat with flag 4'b0000 -> BEQ gives the idle vector.
- IROut = 16'hF000 -> HALT, Halted = 1 held for 20 cycles; Reset low for 1 cycle -> CLR.
- Reset low during EXEC2 of ST -> Mem_CS = 1 that cycle, next state CLR.
